// File: rtl/vector_issue_ctrl.sv
// Vector-side issue controller: FIFO of dispatched vector instructions, one-at-a-time
// issue to the vector unit with completion wait, plus fetch flow-control outputs.
module vector_issue_ctrl #(
  parameter int DEPTH         = 8,
  parameter int FREEZE_THRESH = 6,
  parameter int TIMEOUT       = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        vec_valid,
  input  logic [31:0] vec_inst,
  input  logic [31:0] vec_scalar_op,
  input  logic        vec_sv_in,
  input  logic        exu_done,
  output logic        exu_start,
  output logic [31:0] exu_inst,
  output logic [31:0] exu_scalar,
  output logic        exu_sv,
  output logic        Vector__Stall,
  output logic        Vector__freeze,
  output logic [1:0]  Vector_release_counter,
  output logic        sv_vv,
  output logic        vec_error,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  logic [31:0]   inst_mem   [DEPTH];
  logic [31:0]   scalar_mem [DEPTH];
  logic          sv_mem     [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    timer_q, timer_d;
  logic [1:0]    rc_q, rc_d;
  logic          err_q, err_d;
  logic          stall_q, freeze_q, sv_vv_q;
  logic [31:0]   exu_inst_q, exu_scalar_q;
  logic          exu_sv_q;

  logic          full, pop, push_ok, overflow, done_w, load, timeout;
  logic [31:0]   ld_inst, ld_scalar;
  logic          ld_sv;

  // A slot popped on this edge may be refilled on the same edge, so full only blocks without a pop.
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (state_q == ISSUE);
  assign push_ok  = vec_valid & (~full | pop);
  assign overflow = vec_valid & full & ~pop;
  assign done_w   = exu_done & (state_q == WAIT);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    load    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (exu_done) begin
          if (count_d != '0) begin
            state_d = ISSUE;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Back-to-back issue from an empty FIFO takes the word being pushed this cycle.
  always_comb begin
    ld_inst   = vec_inst;
    ld_scalar = vec_scalar_op;
    ld_sv     = vec_sv_in;
    if (count_q != '0) begin
      ld_inst   = inst_mem[rd_ptr_q];
      ld_scalar = scalar_mem[rd_ptr_q];
      ld_sv     = sv_mem[rd_ptr_q];
    end
  end

  always_comb begin
    rc_d = rc_q;
    if (push_ok)
      rc_d = done_w ? 2'd1 : 2'd0;
    else if (done_w && rc_q != 2'd3)
      rc_d = rc_q + 1'b1;
  end

  assign err_d = err_q | overflow | timeout;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      inst_mem[wr_ptr_q]   <= vec_inst;
      scalar_mem[wr_ptr_q] <= vec_scalar_op;
      sv_mem[wr_ptr_q]     <= vec_sv_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      rc_q         <= '0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      freeze_q     <= 1'b0;
      sv_vv_q      <= 1'b0;
      exu_inst_q   <= 32'h0;
      exu_scalar_q <= 32'h0;
      exu_sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      rc_q     <= rc_d;
      err_q    <= err_d;
      stall_q  <= (count_d != '0) | (state_d != IDLE);
      freeze_q <= (count_d >= CW'(FREEZE_THRESH));
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        sv_vv_q  <= vec_sv_in;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (load) begin
        exu_inst_q   <= ld_inst;
        exu_scalar_q <= ld_scalar;
        exu_sv_q     <= ld_sv;
      end
    end
  end

  assign exu_start              = (state_q == ISSUE);
  assign exu_inst               = exu_inst_q;
  assign exu_scalar             = exu_scalar_q;
  assign exu_sv                 = exu_sv_q;
  assign Vector__Stall          = stall_q;
  assign Vector__freeze         = freeze_q;
  assign Vector_release_counter = rc_q;
  assign sv_vv                  = sv_vv_q;
  assign vec_error              = err_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Directed bench for vector_issue_ctrl: issue order, latency, freeze threshold,
// overflow, back-to-back issue, WAIT timeout and asynchronous reset.
module tb_vector_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        vec_valid, vec_sv_in, exu_done;
  logic [31:0] vec_inst, vec_scalar_op;
  logic        exu_start, exu_sv, Vector__Stall, Vector__freeze, sv_vv, vec_error;
  logic [31:0] exu_inst, exu_scalar;
  logic [1:0]  Vector_release_counter, dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_starts = 0;
  int          starts_before;
  logic [31:0] exp_q[$];

  vector_issue_ctrl dut (
    .CLK(CLK), .RST(RST),
    .vec_valid(vec_valid), .vec_inst(vec_inst), .vec_scalar_op(vec_scalar_op),
    .vec_sv_in(vec_sv_in), .exu_done(exu_done),
    .exu_start(exu_start), .exu_inst(exu_inst), .exu_scalar(exu_scalar), .exu_sv(exu_sv),
    .Vector__Stall(Vector__Stall), .Vector__freeze(Vector__freeze),
    .Vector_release_counter(Vector_release_counter), .sv_vv(sv_vv),
    .vec_error(vec_error), .dbg_state(dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard: every issue must match the oldest accepted, not-yet-issued push
  always @(negedge CLK) begin
    if (!RST && exu_start === 1'b1) begin
      logic [31:0] e;
      n_starts++;
      check("issue_pending", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("issue_inst", exu_inst, e);
        check("issue_scalar", exu_scalar, ~e);
        check("issue_sv", {31'b0, exu_sv}, {31'b0, e[0]});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input bit accept);
    vec_valid     = 1'b1;
    vec_inst      = inst;
    vec_scalar_op = ~inst;
    vec_sv_in     = inst[0];
    if (accept) exp_q.push_back(inst);
    tick();
    vec_valid = 1'b0;
  endtask

  task automatic done_pulse();
    exu_done = 1'b1;
    tick();
    exu_done = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (exu_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("start_within_budget", {31'b0, exu_start}, 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      wait_start(20);
      tick();
      done_pulse();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_start", {31'b0, exu_start}, 32'd0);
    check("rst_inst", exu_inst, 32'h0);
    check("rst_scalar", exu_scalar, 32'h0);
    check("rst_sv", {31'b0, exu_sv}, 32'd0);
    check("rst_stall", {31'b0, Vector__Stall}, 32'd0);
    check("rst_freeze", {31'b0, Vector__freeze}, 32'd0);
    check("rst_rc", {30'b0, Vector_release_counter}, 32'd0);
    check("rst_sv_vv", {31'b0, sv_vv}, 32'd0);
    check("rst_error", {31'b0, vec_error}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; vec_valid = 1'b0; vec_inst = '0; vec_scalar_op = '0;
    vec_sv_in = 1'b0; exu_done = 1'b0;
    repeat (3) tick();
    do_reset();
    tick();

    // single instruction latency and Stall window
    push(32'h0000_1057, 1'b1);
    check("t1_start_early", {31'b0, exu_start}, 32'd0);
    check("t1_stall_on", {31'b0, Vector__Stall}, 32'd1);
    tick();
    check("t1_start", {31'b0, exu_start}, 32'd1);
    check("t1_inst", exu_inst, 32'h0000_1057);
    tick();
    check("t1_start_pulse", {31'b0, exu_start}, 32'd0);
    tick();
    tick();
    check("t1_stall_busy", {31'b0, Vector__Stall}, 32'd1);
    done_pulse();
    check("t1_stall_off", {31'b0, Vector__Stall}, 32'd0);
    check("t1_rc", {30'b0, Vector_release_counter}, 32'd1);
    check("t1_sv_vv", {31'b0, sv_vv}, 32'd1);
    check("t1_state", {30'b0, dbg_state}, 32'd0);
    done_pulse();
    check("t1_done_ignored", {30'b0, Vector_release_counter}, 32'd1);

    // push and done in the same cycle, issue bypassing an empty FIFO
    push(32'hA000_0010, 1'b1);
    tick();
    tick();
    exu_done = 1'b1;
    push(32'hB000_0021, 1'b1);
    exu_done = 1'b0;
    check("t7_start", {31'b0, exu_start}, 32'd1);
    check("t7_inst", exu_inst, 32'hB000_0021);
    check("t7_rc", {30'b0, Vector_release_counter}, 32'd1);
    check("t7_sv_vv", {31'b0, sv_vv}, 32'd1);
    tick();
    done_pulse();
    check("t7_rc2", {30'b0, Vector_release_counter}, 32'd2);
    check("t7_stall_off", {31'b0, Vector__Stall}, 32'd0);

    // back-to-back issue in FIFO order
    push(32'hC000_000A, 1'b1);
    push(32'hC000_000B, 1'b1);
    push(32'hC000_000C, 1'b1);
    tick();
    done_pulse();
    check("t4_start_b", {31'b0, exu_start}, 32'd1);
    check("t4_inst_b", exu_inst, 32'hC000_000B);
    check("t4_rc1", {30'b0, Vector_release_counter}, 32'd1);
    tick();
    done_pulse();
    check("t4_start_c", {31'b0, exu_start}, 32'd1);
    check("t4_inst_c", exu_inst, 32'hC000_000C);
    tick();
    done_pulse();
    check("t4_start_none", {31'b0, exu_start}, 32'd0);
    check("t4_rc3", {30'b0, Vector_release_counter}, 32'd3);
    check("t4_stall_off", {31'b0, Vector__Stall}, 32'd0);

    // freeze threshold: one entry is in flight, so occupancy 6 needs a 7th push
    for (int i = 0; i < 7; i++) begin
      push(32'hD000_0000 + 32'(i), 1'b1);
      if (i == 5) check("t2_freeze_6th", {31'b0, Vector__freeze}, 32'd0);
      if (i == 6) check("t2_freeze_7th", {31'b0, Vector__freeze}, 32'd1);
    end
    done_pulse();
    check("t2_freeze_hold", {31'b0, Vector__freeze}, 32'd1);
    tick();
    check("t2_freeze_drop", {31'b0, Vector__freeze}, 32'd0);
    done_pulse();
    drain(5);
    check("t2_stall_off", {31'b0, Vector__Stall}, 32'd0);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // overflow: 1 in flight + 8 queued, 10th push dropped
    starts_before = n_starts;
    for (int i = 0; i < 10; i++) begin
      push(32'hE000_0000 + 32'(i), i < 9);
      if (i == 8) check("t3_no_error", {31'b0, vec_error}, 32'd0);
      if (i == 9) check("t3_error", {31'b0, vec_error}, 32'd1);
    end
    done_pulse();
    drain(8);
    check("t3_issue_count", 32'(n_starts - starts_before), 32'd9);
    check("t3_rc_sat", {30'b0, Vector_release_counter}, 32'd3);
    check("t3_stall_off", {31'b0, Vector__Stall}, 32'd0);
    check("t3_error_sticky", {31'b0, vec_error}, 32'd1);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // WAIT timeout
    do_reset();
    push(32'hF000_0001, 1'b1);
    push(32'hF000_0002, 1'b1);
    tick();
    repeat (254) tick();
    check("t5_no_timeout", {31'b0, vec_error}, 32'd0);
    check("t5_state_wait", {30'b0, dbg_state}, 32'd2);
    tick();
    check("t5_timeout", {31'b0, vec_error}, 32'd1);
    check("t5_state_idle", {30'b0, dbg_state}, 32'd0);
    check("t5_stall_pending", {31'b0, Vector__Stall}, 32'd1);
    tick();
    check("t5_next_start", {31'b0, exu_start}, 32'd1);
    check("t5_next_inst", exu_inst, 32'hF000_0002);
    tick();
    done_pulse();
    check("t5_stall_off", {31'b0, Vector__Stall}, 32'd0);

    // asynchronous reset during WAIT with 4 queued
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h6000_0000 + 32'(i), 1'b1);
    check("t6_state_wait", {30'b0, dbg_state}, 32'd2);
    starts_before = n_starts;
    do_reset();
    repeat (10) tick();
    check("t6_no_start", 32'(n_starts - starts_before), 32'd0);
    check("t6_stall_off", {31'b0, Vector__Stall}, 32'd0);
    check("t6_state_idle", {30'b0, dbg_state}, 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
